km_spi_tx_arbiter: RTL and testbench
====================================

// Module: km_spi_tx_arbiter
// PURPOSE
//  Shares the single KMBox SPI master between N packet requesters (command FIFO drain, auto-ping, local injectors).
//  Round-robin grant, one outstanding transaction at a time, routes each km_rx response back to its requester.
//  Enforces an inter-frame gap and a response watchdog. Sits between the bridge engine(s) and the SPI master.
// PARAMETERS
//  N_REQ        3            number of requesters (2..8); index 0 is the lowest-numbered slot in round-robin order
//  PKT_W        64           packet width, bits (8-byte fast binary format)
//  MIN_GAP      48           idle clocks enforced between response and next issue (>=1)
//  RSP_TIMEOUT  48_000       clocks allowed from issue to m_rx_valid before abort
// PORTS
//  clk          in   1              clock
//  rst_n        in   1              reset, asynchronous, active-low
//  req_valid    in   N_REQ          per-requester packet pending (level, held until req_grant)
//  req_data     in   N_REQ*PKT_W    packets, requester i at [i*PKT_W +: PKT_W]
//  req_grant    out  N_REQ          one-hot 1-cycle pulse: packet i consumed
//  rsp_valid    out  N_REQ          one-hot 1-cycle pulse: response for requester i on rsp_data
//  rsp_data     out  PKT_W          registered response data
//  m_tx_data    out  PKT_W          packet to SPI master
//  m_tx_valid   out  1              1-cycle start pulse to SPI master
//  m_tx_ready   in   1              SPI master idle
//  m_rx_data    in   PKT_W          SPI master received frame
//  m_rx_valid   in   1              SPI master frame-complete pulse
//  busy         out  1              transaction outstanding (state != IDLE)
//  timeout_err  out  1              1-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = 0; gap/timeout counters 0; owner = 0.
//  FSM: IDLE -> ISSUE -> WAIT_RSP -> GAP -> IDLE.
//   IDLE: if |req_valid && m_tx_ready: pick winner = first set bit at or after rr_ptr (wrapping N_REQ-1 -> 0);
//         latch owner, latch req_data[winner] into m_tx_data, pulse req_grant[winner]; go ISSUE.
//   ISSUE: m_tx_valid=1 for exactly this cycle; load watchdog=0; go WAIT_RSP. rr_ptr <= owner+1 (mod N_REQ).
//   WAIT_RSP: m_tx_ready ignored. On m_rx_valid: rsp_data<=m_rx_data, rsp_valid[owner] pulses next cycle; go GAP.
//         If watchdog reaches RSP_TIMEOUT-1 without m_rx_valid: pulse timeout_err, no rsp_valid, go GAP.
//   GAP: count MIN_GAP clocks, then IDLE. New requests are not granted in GAP.
//  Latency: req_valid (with m_tx_ready high, IDLE) -> req_grant next edge -> m_tx_valid one cycle after grant.
//  Handshake: requester must hold req_valid/data stable until req_grant; req_grant never asserted when req_valid=0.
//   Dropping req_valid before grant is legal (request withdrawn, no grant issued).
//  Fairness: a continuously requesting source waits at most N_REQ-1 transactions.
//  Stray m_rx_valid in IDLE/ISSUE/GAP: ignored, no rsp_valid (counted nowhere).
//  m_rx_valid in the same cycle as watchdog expiry: response wins, no timeout_err.
//  m_tx_ready low in IDLE: hold, no grant; rr_ptr unchanged.
//  Counters: watchdog and gap counters sized $clog2(max)+1, saturate-free (reset on state entry).
//  Asynchronous reset mid-transaction: return to IDLE immediately; in-flight response later arrives in IDLE, ignored.
//  Single driver per output; all outputs registered.
// STRUCTURE
//  Package km_bridge_pkg: PKT_W, opcode constants KM_OP_NOP=8'h00, KM_OP_PING=8'hFE, FSM state enum.
//  Sub-module rr_arbiter_n (N_REQ, combinational pick of first set bit from rr_ptr + registered ptr update).
//  FSM, watchdog, gap counter and response demux remain in km_spi_tx_arbiter.
// TESTING
//  1. req_valid=3'b001, data0=FE00..00, m_tx_ready=1 -> req_grant=001 next edge, m_tx_valid 1 cycle with FE00..00.
//  2. req_valid=3'b111 held, model responds 10 clk after each issue -> grant order 0,1,2,0 and rsp_valid matches owner.
//  3. No m_rx_valid, RSP_TIMEOUT=100 -> timeout_err pulse exactly 100 clk after m_tx_valid; IDLE after MIN_GAP.
//  4. m_rx_valid in GAP and IDLE (no issue pending) -> no rsp_valid, state unchanged.
//  5. m_tx_ready=0 with req_valid=010 for 20 clk -> no grant; ready rises -> grant=010 next edge.
//  6. rst_n low during WAIT_RSP, release, late m_rx_valid -> all outputs 0, no rsp_valid, next grant from rr_ptr=0.

Source files
------------

// File: rtl/km_bridge_pkg.sv
// rtl/km_bridge_pkg.sv - shared packet width, opcode constants and arbiter FSM states
package km_bridge_pkg;

  localparam int PKT_W = 64;

  localparam logic [7:0] KM_OP_NOP  = 8'h00;
  localparam logic [7:0] KM_OP_PING = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_GAP      = 2'd3
  } km_arb_state_e;

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - round-robin pick of the first pending requester at or after the pointer
module rr_arbiter_n #(
  parameter int N_REQ = 3,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  input  logic [IDX_W-1:0] owner_i,
  output logic             any_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic [N_REQ-1:0] win_oh_o
);

  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_REQ-1);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // One extra bit on the sum keeps ptr+i from wrapping before the mod-N fold.
  always_comb begin
    any_o     = 1'b0;
    win_idx_o = '0;
    win_oh_o  = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= N_EXT) sum = sum - N_EXT;
      cand = sum[IDX_W-1:0];
      if (!any_o && req_i[cand]) begin
        any_o           = 1'b1;
        win_idx_o       = cand;
        win_oh_o[cand]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = (owner_i == LAST) ? '0 : owner_i + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/km_spi_tx_arbiter.sv
// rtl/km_spi_tx_arbiter.sv - shares one SPI master between N requesters with response routing, gap and watchdog
module km_spi_tx_arbiter #(
  parameter int N_REQ       = 3,
  parameter int PKT_W       = 64,
  parameter int MIN_GAP     = 48,
  parameter int RSP_TIMEOUT = 48000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*PKT_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_grant,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [PKT_W-1:0]       rsp_data,
  output logic [PKT_W-1:0]       m_tx_data,
  output logic                   m_tx_valid,
  input  logic                   m_tx_ready,
  input  logic [PKT_W-1:0]       m_rx_data,
  input  logic                   m_rx_valid,
  output logic                   busy,
  output logic                   timeout_err
);

  import km_bridge_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(RSP_TIMEOUT) + 1;
  localparam int GAP_W = $clog2(MIN_GAP) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(RSP_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);

  km_arb_state_e    state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [PKT_W-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [PKT_W-1:0] rsp_data_q, rsp_data_d;
  logic             timeout_q, timeout_d;
  logic             busy_q;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             rr_any;
  logic [IDX_W-1:0] rr_idx;
  logic [N_REQ-1:0] rr_oh;
  logic             rr_advance;

  assign rr_advance = (state_q == ST_ISSUE);

  rr_arbiter_n #(.N_REQ(N_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .advance_i (rr_advance),
    .owner_i   (owner_q),
    .any_o     (rr_any),
    .win_idx_o (rr_idx),
    .win_oh_o  (rr_oh)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    grant_d     = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    timeout_d   = 1'b0;
    wd_d        = wd_q;
    gap_d       = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_any && m_tx_ready) begin
          owner_d   = rr_idx;
          tx_data_d = req_data[rr_idx*PKT_W +: PKT_W];
          grant_d   = rr_oh;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tx_valid_d = 1'b1;
        wd_d       = '0;
        state_d    = ST_WAIT_RSP;
      end
      // A response landing on the expiry cycle is delivered rather than aborted.
      ST_WAIT_RSP: begin
        if (m_rx_valid) begin
          rsp_data_d           = m_rx_data;
          rsp_valid_d[owner_q] = 1'b1;
          gap_d                = '0;
          state_d              = ST_GAP;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      timeout_q   <= timeout_d;
      busy_q      <= (state_d != ST_IDLE);
      wd_q        <= wd_d;
      gap_q       <= gap_d;
    end
  end

  assign req_grant   = grant_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign m_tx_data   = tx_data_q;
  assign m_tx_valid  = tx_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_km_spi_tx_arbiter.sv
// tb/tb_km_spi_tx_arbiter.sv - scoreboard bench for km_spi_tx_arbiter with a round-robin reference model
module tb_km_spi_tx_arbiter;

  localparam int N_REQ       = 3;
  localparam int PKT_W       = 64;
  localparam int MIN_GAP     = 6;
  localparam int RSP_TIMEOUT = 100;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*PKT_W-1:0] req_data = '0;
  logic [N_REQ-1:0]       req_grant;
  logic [N_REQ-1:0]       rsp_valid;
  logic [PKT_W-1:0]       rsp_data;
  logic [PKT_W-1:0]       m_tx_data;
  logic                   m_tx_valid;
  logic                   m_tx_ready = 1'b1;
  logic [PKT_W-1:0]       m_rx_data = '0;
  logic                   m_rx_valid = 1'b0;
  logic                   busy;
  logic                   timeout_err;

  km_spi_tx_arbiter #(
    .N_REQ(N_REQ), .PKT_W(PKT_W), .MIN_GAP(MIN_GAP), .RSP_TIMEOUT(RSP_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .m_tx_data(m_tx_data), .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready),
    .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr = 0;
  int exp_idle = -1;
  int last_grant_cyc = -10;

  int         exp_grant_q[$];
  int         exp_grant_cyc_q[$];
  logic [63:0] exp_tx_q[$];
  int         exp_rsp_own_q[$];
  logic [63:0] exp_rsp_data_q[$];
  int         exp_to_q[$];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] pend, input int ptr);
    for (int i = 0; i < N_REQ; i++) begin
      int j;
      j = (ptr + i) % N_REQ;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check(req_grant == 0,   {tag, "_req_grant"},   req_grant, 0);
    check(rsp_valid == 0,   {tag, "_rsp_valid"},   rsp_valid, 0);
    check(rsp_data == 0,    {tag, "_rsp_data"},    rsp_data, 0);
    check(m_tx_data == 0,   {tag, "_m_tx_data"},   m_tx_data, 0);
    check(m_tx_valid == 0,  {tag, "_m_tx_valid"},  m_tx_valid, 0);
    check(busy == 0,        {tag, "_busy"},        busy, 0);
    check(timeout_err == 0, {tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic set_req(input int i, input logic [63:0] d);
    req_valid[i] = 1'b1;
    req_data[i*PKT_W +: PKT_W] = d;
  endtask

  task automatic expect_grant(input int gcyc, output int w);
    w = pick(req_valid, m_ptr);
    if (w < 0) begin
      check(0, "model_no_request", 0, 1);
      return;
    end
    exp_grant_q.push_back(w);
    exp_grant_cyc_q.push_back(gcyc);
    exp_tx_q.push_back(req_data[w*PKT_W +: PKT_W]);
    m_ptr = (w + 1) % N_REQ;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int k = 0; k < 400 && idx < 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) if (req_grant[i]) idx = i;
    end
    if (idx < 0) check(0, "grant_wait_expired", 0, 1);
    else req_valid[idx] = 1'b0;
  endtask

  task automatic wait_tx(output int t);
    t = -1;
    for (int k = 0; k < 50 && t < 0; k++) begin
      @(negedge clk);
      if (m_tx_valid) t = cyc;
    end
    if (t < 0) check(0, "tx_wait_expired", 0, 1);
  endtask

  task automatic respond(input int d, input int own, input bit expect_it);
    logic [63:0] v;
    v = {$urandom, $urandom};
    repeat (d) @(negedge clk);
    m_rx_valid = 1'b1;
    m_rx_data  = v;
    if (expect_it) begin
      exp_rsp_own_q.push_back(own);
      exp_rsp_data_q.push_back(v);
    end
    @(negedge clk);
    m_rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(!busy, "idle_wait_expired", busy, 0);
  endtask

  task automatic txn(input int d, input bit to, input int gcyc, output int w);
    int idx, t;
    expect_grant(gcyc, w);
    if (w < 0) return;
    wait_grant(idx);
    if (idx < 0) return;
    wait_tx(t);
    if (t < 0) return;
    if (to) begin
      exp_to_q.push_back(t + RSP_TIMEOUT);
      wait_idle();
    end else begin
      respond(d, w, 1'b1);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin
    logic prev_busy;
    int w, gc, et, own;
    logic [63:0] ed;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        exp_idle  = -1;
      end else begin
        if (req_grant != 0) begin
          if (exp_grant_q.size() == 0) check(0, "unexpected_grant", req_grant, 0);
          else begin
            w  = exp_grant_q.pop_front();
            gc = exp_grant_cyc_q.pop_front();
            check(req_grant == 3'(1 << w), "grant_onehot", req_grant, 3'(1 << w));
            check(busy == 1'b1, "busy_on_grant", busy, 1);
            if (gc >= 0) check(cyc == gc, "grant_latency", cyc, gc);
            last_grant_cyc = cyc;
          end
        end
        if (m_tx_valid) begin
          if (exp_tx_q.size() == 0) check(0, "unexpected_tx_valid", m_tx_valid, 0);
          else begin
            ed = exp_tx_q.pop_front();
            check(m_tx_data == ed, "tx_data", m_tx_data, ed);
            check(cyc == last_grant_cyc + 1, "tx_after_grant", cyc, last_grant_cyc + 1);
          end
        end
        if (rsp_valid != 0) begin
          if (exp_rsp_own_q.size() == 0) check(0, "unexpected_rsp_valid", rsp_valid, 0);
          else begin
            own = exp_rsp_own_q.pop_front();
            ed  = exp_rsp_data_q.pop_front();
            check(rsp_valid == 3'(1 << own), "rsp_owner", rsp_valid, 3'(1 << own));
            check(rsp_data == ed, "rsp_data", rsp_data, ed);
            exp_idle = cyc + MIN_GAP;
          end
        end
        if (timeout_err) begin
          if (exp_to_q.size() == 0) check(0, "unexpected_timeout", timeout_err, 0);
          else begin
            et = exp_to_q.pop_front();
            check(cyc == et, "timeout_cycle", cyc, et);
            exp_idle = cyc + MIN_GAP;
          end
        end
        if (prev_busy && !busy) begin
          if (exp_idle >= 0) check(cyc == exp_idle, "gap_length", cyc, exp_idle);
          else check(0, "unexpected_idle", cyc, 0);
          exp_idle = -1;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int w, d;
    bit to;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All three requesting continuously, 10-clock responses: order 0,1,2,0.
    for (int i = 0; i < N_REQ; i++) set_req(i, {$urandom, $urandom});
    for (int n = 0; n < 4; n++) begin
      txn(9, 1'b0, (n == 0) ? cyc + 1 : -1, w);
      if (n < 3 && w >= 0) set_req(w, {$urandom, $urandom});
    end
    req_valid = '0;
    wait_idle();

    // Single ping from requester 0, grant on the next edge.
    set_req(0, 64'hFE00_0000_0000_0000);
    txn(5, 1'b0, cyc + 1, w);
    wait_idle();

    // Watchdog abort, then a response exactly on the expiry cycle.
    set_req(2, {$urandom, $urandom});
    txn(0, 1'b1, -1, w);
    set_req(1, {$urandom, $urandom});
    txn(RSP_TIMEOUT - 1, 1'b0, -1, w);

    // Stray responses in GAP and in IDLE.
    respond(0, 0, 1'b0);
    wait_idle();
    respond(1, 0, 1'b0);
    repeat (5) @(negedge clk);
    check(busy == 1'b0, "stray_idle_busy", busy, 0);

    // Master not ready holds off the grant.
    m_tx_ready = 1'b0;
    set_req(1, {$urandom, $urandom});
    repeat (20) @(negedge clk);
    check(busy == 1'b0, "not_ready_busy", busy, 0);
    m_tx_ready = 1'b1;
    txn(4, 1'b0, cyc + 1, w);
    wait_idle();

    // Reset while waiting for a response; the late response must vanish.
    set_req(0, {$urandom, $urandom});
    expect_grant(-1, w);
    wait_grant(w);
    wait_tx(d);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    respond(2, 0, 1'b0);
    repeat (5) @(negedge clk);
    check(busy == 1'b0, "late_rsp_busy", busy, 0);
    set_req(0, {$urandom, $urandom});
    set_req(1, {$urandom, $urandom});
    txn(3, 1'b0, cyc + 1, w);

    // Randomised traffic against the round-robin model.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < N_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, {$urandom, $urandom});
      if (req_valid == 0) set_req($urandom_range(0, N_REQ - 1), {$urandom, $urandom});
      to = ($urandom_range(0, 7) == 0);
      d  = $urandom_range(0, 20);
      txn(d, to, -1, w);
    end
    req_valid = '0;
    wait_idle();

    repeat (20) @(negedge clk);
    check(exp_grant_q.size() + exp_tx_q.size() + exp_rsp_own_q.size() + exp_to_q.size() == 0,
          "scoreboard_drained",
          exp_grant_q.size() + exp_tx_q.size() + exp_rsp_own_q.size() + exp_to_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
